// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result unloader: size defaults, FSM states, address helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package fft_pkg;

   localparam int LOG2N_DEF = 10;
   localparam int DW_DEF    = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN
   } state_t;

   // Reverse the low w bits of v; bits at and above w come back as zero.
   function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < w) begin
            r[4'(i)] = v[4'(w - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_unload_fifo.sv
// Small synchronous FIFO holding RAM read data until the consumer takes it.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: none internally; the caller keeps push/pop legal using the count output.
module fft_unload_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;

   // Storage array: written on push, never reset (occupancy is tracked by cnt_q).
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= push_dat;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign head_dat = mem_q[rd_q];
   assign count    = cnt_q;

endmodule

// File: rtl/fft_1024_unload.sv
// Streams one finished FFT result bank out in natural order, then hands the bank back.
// Latency: done -> first RAM read +1 cycle -> first out_valid +3 cycles; one beat/cycle.
// Backpressure: reads stop while buffered + in-flight samples reach 3; nothing is dropped.
// Build option FFT_UNLOAD_BITREV_EN: defined -> bit-reversed RAM addressing, else linear.
module fft_1024_unload
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic              clock_c,
   input  logic              reset_n,
   input  logic              done,
   input  logic              done_bank,
   output logic              release_o,
   output logic              ram_rd_en,
   output logic              ram_rd_bank,
   output logic [LOG2N-1:0]  ram_rd_addr,
   input  logic [2*DW-1:0]   ram_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*DW-1:0]   out_data,
   output logic [LOG2N-1:0]  out_index,
   output logic              out_last,
   output logic              overrun
);

   localparam logic [LOG2N-1:0] K_LAST = '1;

   state_t           state_q;
   logic [LOG2N-1:0] k_q;
   logic [LOG2N-1:0] idx_q;
   logic [LOG2N-1:0] rd_addr_q;
   logic [LOG2N-1:0] rd_addr_d;
   logic             rd_en_q;
   logic             rd_pend_q;
   logic             bank_q;
   logic             pend_vld_q;
   logic             pend_bank_q;
   logic             rel_q;
   logic             ovr_q;

   logic [2:0]       fifo_cnt;
   logic [2:0]       fifo_cnt_d;
   logic [2*DW-1:0]  fifo_head;
   logic             beat;
   logic             can_rd;
   logic             start_pend;
   logic             start_new;
   logic             done_to_pend;
   logic             done_ovr;

   fft_unload_fifo #(
      .W     (2*DW),
      .DEPTH (4)
   ) u_fifo (
      .clk      (clock_c),
      .rst_n    (reset_n),
      .push     (rd_pend_q),
      .push_dat (ram_rd_data),
      .pop      (beat),
      .head_dat (fifo_head),
      .count    (fifo_cnt)
   );

`ifdef FFT_UNLOAD_BITREV_EN
   assign rd_addr_d = LOG2N'(bitrev(16'(k_q), LOG2N));
`else
   assign rd_addr_d = k_q;
`endif

   assign out_valid = (fifo_cnt != 3'd0);
   assign beat      = out_valid && out_ready;
   assign out_data  = out_valid ? fifo_head : '0;
   assign out_index = idx_q;
   assign out_last  = out_valid && (idx_q == K_LAST);

   // Credit uses the FIFO level after this edge plus the read whose data is not yet on the bus,
   // so a full-rate stream keeps exactly three samples in the pipeline.
   assign fifo_cnt_d = fifo_cnt + 3'(rd_pend_q) - 3'(beat);
   assign can_rd     = (fifo_cnt_d + 3'(rd_en_q)) < 3'd3;

   // A held done is older than a fresh one, so it wins when both are available in IDLE.
   assign start_pend   = (state_q == ST_IDLE) && pend_vld_q;
   assign start_new    = (state_q == ST_IDLE) && !pend_vld_q && done;
   assign done_to_pend = done && !start_new && (!pend_vld_q || start_pend);
   assign done_ovr     = done && pend_vld_q && !start_pend;

   // Control FSM with registered RAM strobe, release pulse, pending-done slot and overrun flag.
   always_ff @(posedge clock_c) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         idx_q       <= '0;
         rd_addr_q   <= '0;
         rd_en_q     <= 1'b0;
         rd_pend_q   <= 1'b0;
         bank_q      <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_bank_q <= 1'b0;
         rel_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         rd_en_q   <= 1'b0;
         rel_q     <= 1'b0;
         rd_pend_q <= rd_en_q;

         if (beat) begin
            idx_q <= out_last ? '0 : idx_q + 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               // Sample 0 is read on the start edge itself (address 0 in either mode),
               // so the counter resumes at 1.
               if (start_pend || start_new) begin
                  state_q   <= ST_READ;
                  bank_q    <= start_pend ? pend_bank_q : done_bank;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  k_q       <= LOG2N'(1);
               end
            end
            ST_READ: begin
               if (can_rd) begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= rd_addr_d;
                  k_q       <= k_q + 1'b1;
                  if (k_q == K_LAST) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (beat && out_last) begin
                  state_q <= ST_IDLE;
                  rel_q   <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (start_pend) begin
            pend_vld_q <= 1'b0;
         end
         if (done_to_pend) begin
            pend_vld_q  <= 1'b1;
            pend_bank_q <= done_bank;
         end
         if (done_ovr) begin
            ovr_q <= 1'b1;
         end
      end
   end

   assign release_o   = rel_q;
   assign ram_rd_en   = rd_en_q;
   assign ram_rd_bank = bank_q;
   assign ram_rd_addr = rd_addr_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_fft_1024_unload.sv
// Bench for fft_1024_unload: RAM model, random backpressure, reference model of the stream.
// Latency: n/a.
// Backpressure: out_ready is either held high or randomly dropped ~30% of cycles.
module tb_fft_1024_unload;

   localparam int N = 1024;

   logic        clock_c = 1'b0;
   logic        reset_n;
   logic        done;
   logic        done_bank;
   logic        release_o;
   logic        ram_rd_en;
   logic        ram_rd_bank;
   logic [9:0]  ram_rd_addr;
   logic [15:0] ram_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [9:0]  out_index;
   logic        out_last;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rdy_mode = 0;

   // monitor records
   int rd_addr_q[$];
   int rd_bank_q[$];
   int rd_cyc_q[$];
   int bt_idx_q[$];
   int bt_dat_q[$];
   int bt_last_q[$];
   int bt_cyc_q[$];
   int rel_cyc_q[$];
   int stab_err = 0;
   int max_out  = 0;
   int n_rd     = 0;
   int n_bt     = 0;
   bit prev_stall = 1'b0;
   logic [15:0] prev_dat;
   logic [9:0]  prev_idx;
   logic        prev_last;

   fft_1024_unload dut (
      .clock_c     (clock_c),
      .reset_n     (reset_n),
      .done        (done),
      .done_bank   (done_bank),
      .release_o   (release_o),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_bank (ram_rd_bank),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_last    (out_last),
      .overrun     (overrun)
   );

   always #5 clock_c = ~clock_c;
   always @(posedge clock_c) cyc <= cyc + 1;

   // Content of every RAM word: distinct per address (odd multiplier) and per bank.
   function automatic logic [15:0] ram_word(input logic bank, input int a);
      int v;
      v = a * 40503 + (bank ? 4660 : 0);
      return v[15:0] ^ 16'h5a5a;
   endfunction

   // RAM address holding natural-frequency sample k.
   function automatic int exp_addr(input int k);
      int r;
`ifdef FFT_UNLOAD_BITREV_EN
      r = 0;
      for (int b = 0; b < 10; b++) begin
         if ((k & (1 << b)) != 0) r = r | (1 << (9 - b));
      end
`else
      r = k;
`endif
      return r;
   endfunction

   // Result RAM: data 1 cycle after the strobe, garbage otherwise.
   always @(posedge clock_c) begin
      ram_rd_data <= ram_rd_en ? ram_word(ram_rd_bank, int'(ram_rd_addr)) : 16'($urandom);
   end

   // Downstream consumer.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock_c);
         #1;
         out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      end
   end

   // Passive monitor sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clock_c);
         if (reset_n === 1'b1) begin
            if (ram_rd_en) begin
               rd_addr_q.push_back(int'(ram_rd_addr));
               rd_bank_q.push_back(int'(ram_rd_bank));
               rd_cyc_q.push_back(cyc);
               n_rd++;
            end
            if (n_rd - n_bt > max_out) max_out = n_rd - n_bt;
            if (prev_stall && (!out_valid || out_data !== prev_dat ||
                               out_index !== prev_idx || out_last !== prev_last))
               stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_idx   = out_index;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
               bt_idx_q.push_back(int'(out_index));
               bt_dat_q.push_back(int'(out_data));
               bt_last_q.push_back(int'(out_last));
               bt_cyc_q.push_back(cyc);
               n_bt++;
            end
            if (release_o) rel_cyc_q.push_back(cyc);
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d required finish earlier", cyc);
      $fatal(1);
   end

   task automatic clear_mon();
      rd_addr_q.delete(); rd_bank_q.delete(); rd_cyc_q.delete();
      bt_idx_q.delete(); bt_dat_q.delete(); bt_last_q.delete(); bt_cyc_q.delete();
      rel_cyc_q.delete();
      stab_err = 0; max_out = 0; n_rd = 0; n_bt = 0; prev_stall = 1'b0;
   endtask

   task automatic pulse_done(input logic b, output int t);
      @(posedge clock_c);
      #1;
      done      = 1'b1;
      done_bank = b;
      t         = cyc;
      @(posedge clock_c);
      #1;
      done      = 1'b0;
   endtask

   task automatic wait_rel(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (rel_cyc_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock_c);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [47:0] outs;
      reset_n = 1'b0; done = 1'b0; done_bank = 1'b0;
      repeat (3) @(posedge clock_c);
      @(negedge clock_c);
      outs = {release_o, ram_rd_en, ram_rd_bank, ram_rd_addr, out_valid,
              out_data, out_index, out_last, overrun};
      checks++;
      if (outs !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", outs);
      end
      @(posedge clock_c); #1; reset_n = 1'b1;
      repeat (5) @(posedge clock_c);
      @(negedge clock_c);
      checks++;
      if (ram_rd_en !== 1'b0 || out_valid !== 1'b0 || release_o !== 1'b0) begin
         errors++; $display("FAIL idle_quiet got rd_en=%b valid=%b rel=%b want 0 0 0",
                            ram_rd_en, out_valid, release_o);
      end
   endtask

   task automatic test_single();
      int t; bit ok;
      clear_mon(); rdy_mode = 0;
      pulse_done(1'b1, t);
      wait_rel(1, 1500, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout got no release want release"); end
      checks++;
      if (bt_idx_q.size() != N) begin
         errors++; $display("FAIL single_beats got %0d want %0d", bt_idx_q.size(), N);
      end
      for (int i = 0; i < bt_idx_q.size(); i++) begin
         checks++;
         if (bt_idx_q[i] != i || bt_dat_q[i] != int'(ram_word(1'b1, exp_addr(i))) ||
             bt_last_q[i] != int'(i == N - 1) || bt_cyc_q[i] != t + 3 + i) begin
            errors++;
            $display("FAIL single_beat i=%0d got idx=%0d dat=%h last=%0d cyc=%0d want idx=%0d dat=%h last=%0d cyc=%0d",
                     i, bt_idx_q[i], bt_dat_q[i], bt_last_q[i], bt_cyc_q[i],
                     i, ram_word(1'b1, exp_addr(i)), int'(i == N - 1), t + 3 + i);
         end
      end
      checks++;
      if (rd_addr_q.size() != N) begin
         errors++; $display("FAIL single_reads got %0d want %0d", rd_addr_q.size(), N);
      end
      for (int j = 0; j < rd_addr_q.size(); j++) begin
         checks++;
         if (rd_addr_q[j] != exp_addr(j) || rd_bank_q[j] != 1) begin
            errors++;
            $display("FAIL single_addr j=%0d got addr=%0d bank=%0d want addr=%0d bank=1",
                     j, rd_addr_q[j], rd_bank_q[j], exp_addr(j));
         end
      end
      checks++;
      if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != t + 1) begin
         errors++; $display("FAIL single_first_read got cyc=%0d want %0d",
                            (rd_cyc_q.size() == 0) ? -1 : rd_cyc_q[0], t + 1);
      end
      checks++;
      if (rel_cyc_q.size() != 1 || rel_cyc_q[0] != t + 1027) begin
         errors++; $display("FAIL single_release got n=%0d cyc=%0d want n=1 cyc=%0d",
                            rel_cyc_q.size(), (rel_cyc_q.size() == 0) ? -1 : rel_cyc_q[0], t + 1027);
      end
      checks++;
      if (max_out > 3) begin errors++; $display("FAIL single_outstanding got %0d want <=3", max_out); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun got %b want 0", overrun); end
   endtask

   task automatic test_stall();
      int t; bit ok;
      clear_mon(); rdy_mode = 1;
      pulse_done(1'b0, t);
      wait_rel(1, 6000, ok);
      rdy_mode = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_timeout got no release want release"); end
      checks++;
      if (bt_idx_q.size() != N) begin
         errors++; $display("FAIL stall_beats got %0d want %0d", bt_idx_q.size(), N);
      end
      for (int i = 0; i < bt_idx_q.size(); i++) begin
         checks++;
         if (bt_idx_q[i] != i || bt_dat_q[i] != int'(ram_word(1'b0, exp_addr(i))) ||
             bt_last_q[i] != int'(i == N - 1)) begin
            errors++;
            $display("FAIL stall_beat i=%0d got idx=%0d dat=%h last=%0d want idx=%0d dat=%h last=%0d",
                     i, bt_idx_q[i], bt_dat_q[i], bt_last_q[i],
                     i, ram_word(1'b0, exp_addr(i)), int'(i == N - 1));
         end
      end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL stall_stability got %0d want 0", stab_err); end
      checks++;
      if (max_out > 3) begin errors++; $display("FAIL stall_outstanding got %0d want <=3", max_out); end
      checks++;
      if (rd_addr_q.size() != N) begin
         errors++; $display("FAIL stall_reads got %0d want %0d", rd_addr_q.size(), N);
      end
   endtask

   task automatic test_pending();
      int t1; int t2; bit ok; int b;
      clear_mon(); rdy_mode = 0;
      pulse_done(1'b1, t1);
      repeat (200) @(posedge clock_c);
      pulse_done(1'b0, t2);
      wait_rel(2, 2600, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pend_timeout got %0d releases want 2", rel_cyc_q.size()); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL pend_overrun got %b want 0", overrun); end
      checks++;
      if (bt_idx_q.size() != 2 * N) begin
         errors++; $display("FAIL pend_beats got %0d want %0d", bt_idx_q.size(), 2 * N);
      end
      for (int i = 0; i < bt_idx_q.size(); i++) begin
         b = (i < N) ? 1 : 0;
         checks++;
         if (bt_idx_q[i] != i % N || bt_dat_q[i] != int'(ram_word(b[0], exp_addr(i % N)))) begin
            errors++;
            $display("FAIL pend_beat i=%0d got idx=%0d dat=%h want idx=%0d dat=%h",
                     i, bt_idx_q[i], bt_dat_q[i], i % N, ram_word(b[0], exp_addr(i % N)));
         end
      end
      checks++;
      if (rel_cyc_q.size() < 1 || rd_cyc_q.size() <= N || rd_cyc_q[N] != rel_cyc_q[0] + 1 ||
          rd_bank_q[N] != 0) begin
         errors++;
         $display("FAIL pend_turnaround got rd=%0d rel=%0d want rd=rel+1 bank 0",
                  (rd_cyc_q.size() > N) ? rd_cyc_q[N] : -1,
                  (rel_cyc_q.size() > 0) ? rel_cyc_q[0] : -1);
      end
      checks++;
      if (rel_cyc_q.size() < 1 || rel_cyc_q[0] != t1 + 1027) begin
         errors++; $display("FAIL pend_first_release got %0d want %0d",
                            (rel_cyc_q.size() > 0) ? rel_cyc_q[0] : -1, t1 + 1027);
      end
   endtask

   task automatic test_overrun();
      int t1; int t2; int t3; bit ok; int nb0;
      clear_mon(); rdy_mode = 0;
      pulse_done(1'b1, t1);
      repeat (100) @(posedge clock_c);
      pulse_done(1'b1, t2);
      @(negedge clock_c);
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
      repeat (50) @(posedge clock_c);
      pulse_done(1'b0, t3);
      @(negedge clock_c);
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
      wait_rel(2, 2600, ok);
      repeat (1200) @(posedge clock_c);
      #1;
      checks++;
      if (!ok || rel_cyc_q.size() != 2) begin
         errors++; $display("FAIL ovr_releases got %0d want 2", rel_cyc_q.size());
      end
      checks++;
      if (rd_addr_q.size() != 2 * N) begin
         errors++; $display("FAIL ovr_reads got %0d want %0d", rd_addr_q.size(), 2 * N);
      end
      nb0 = 0;
      foreach (rd_bank_q[j]) if (rd_bank_q[j] == 0) nb0++;
      checks++;
      if (nb0 != 0) begin errors++; $display("FAIL ovr_dropped_bank got %0d reads of bank 0 want 0", nb0); end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
   endtask

   task automatic test_midreset();
      int t; bit ok; logic [47:0] outs;
      clear_mon(); rdy_mode = 0;
      pulse_done(1'b0, t);
      ok = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         if (bt_idx_q.size() >= 500) begin ok = 1'b1; break; end
         @(posedge clock_c); #1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_reach500 got %0d beats want 500", bt_idx_q.size()); end
      reset_n = 1'b0;
      @(posedge clock_c);
      @(negedge clock_c);
      outs = {release_o, ram_rd_en, ram_rd_bank, ram_rd_addr, out_valid,
              out_data, out_index, out_last, overrun};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs got %h want 0", outs); end
      @(posedge clock_c); #1; reset_n = 1'b1;
      clear_mon();
      repeat (30) @(posedge clock_c);
      #1;
      checks++;
      if (rel_cyc_q.size() != 0 || rd_addr_q.size() != 0 || bt_idx_q.size() != 0) begin
         errors++; $display("FAIL mid_quiet got rel=%0d rd=%0d bt=%0d want 0 0 0",
                            rel_cyc_q.size(), rd_addr_q.size(), bt_idx_q.size());
      end
      pulse_done(1'b1, t);
      wait_rel(1, 1500, ok);
      checks++;
      if (!ok || bt_idx_q.size() != N) begin
         errors++; $display("FAIL mid_restart_beats got %0d want %0d", bt_idx_q.size(), N);
      end
      for (int i = 0; i < bt_idx_q.size(); i++) begin
         checks++;
         if (bt_idx_q[i] != i || bt_dat_q[i] != int'(ram_word(1'b1, exp_addr(i)))) begin
            errors++;
            $display("FAIL mid_restart_beat i=%0d got idx=%0d dat=%h want idx=%0d dat=%h",
                     i, bt_idx_q[i], bt_dat_q[i], i, ram_word(1'b1, exp_addr(i)));
         end
      end
      checks++;
      if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != t + 1) begin
         errors++; $display("FAIL mid_first_read got %0d want %0d",
                            (rd_cyc_q.size() == 0) ? -1 : rd_cyc_q[0], t + 1);
      end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", overrun); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_pending();
      test_overrun();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_1024_unload.md
# fft_1024_unload

Output unloader for the 1024-point FFT core. When the core signals that a transform result is complete in one bank of its ping-pong result RAM, this block reads that bank and streams the 1024 complex samples out on a valid/ready interface. Reads are in natural frequency order, with bit-reversed RAM addressing. When the bank has been fully read, the block returns it to the core with a release pulse. It sits between the core's result RAM read port and the downstream consumer, and is the reading end of the core's result-writer interface.

## Interface
Parameters:
- LOG2N, 10, log2 of transform length (N = 1024)
- DW, 8, bit width of each real and imaginary component

Ports:
- clock_c  in  1  sole clock; all logic on its rising edge
- reset_n  in  1  synchronous reset, active-low
- done  in  1  single-cycle pulse from the core: result bank ready
- done_bank  in  1  bank index accompanying done
- release  out  1  single-cycle pulse: the bank being read is free again
- ram_rd_en  out  1  RAM read strobe
- ram_rd_bank  out  1  bank select for the read
- ram_rd_addr  out  LOG2N  read address
- ram_rd_data  in  2*DW  {re, im}; valid exactly 1 cycle after ram_rd_en
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_data  out  2*DW  {re, im}
- out_index  out  LOG2N  natural-order index of out_data
- out_last  out  1  high with index N-1
- overrun  out  1  sticky error flag; cleared only by reset

## Operation
- States:
  - IDLE: waits for done.
  - READ: issues the read addresses.
  - DRAIN: all N reads issued; waits for the buffer to empty.
- IDLE → READ on done: latch done_bank, clear the read counter k.
- READ issues ram_rd_en, address = bitrev(k), then k++.
  - A read is issued only when buffer count + in-flight reads < 3.
- The buffer is a 4-entry FIFO that captures ram_rd_data on the cycle after each read.
- out_index comes from a separate counter of accepted beats.
- READ → DRAIN after the read with k = N-1.
- DRAIN → IDLE when the beat with out_last is accepted.
  - release pulses on the following cycle.
- Pending done: a done arriving outside IDLE is latched (one deep, with its bank).
  - A pending done starts READ on the cycle after the release pulse.
- Overrun: a done arriving while a pending done is already held sets overrun. That done is dropped.
- done on the same cycle as release: it is treated as pending, not as overrun.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While stalled, out_data, out_index and out_last hold stable.
  - out_valid never drops without a transfer.
- Reset (including mid-transfer): the FSM goes to IDLE and the FIFO and pending done are cleared. No release is issued for the abandoned bank.
  - The following outputs are 0 during and after reset: release, ram_rd_en, ram_rd_bank, ram_rd_addr, out_valid, out_data, out_index, out_last, overrun.
- Counters are LOG2N bits and wrap only via the state transition; k is never used past N-1.

## Timing
- done at cycle t → first ram_rd_en at t+1 → data captured at t+2 → out_valid at t+3.
- With out_ready held high: one beat per cycle. out_last is at t+3+1023, release at t+1027.
- Back-pressure: no reads are issued while buffer count + in-flight ≥ 3. No sample is ever lost.
- Turnaround with a pending done: the next bank's first ram_rd_en comes 1 cycle after release.

## Configuration
- FFT_UNLOAD_BITREV_EN:
  - Defined: ram_rd_addr = bit-reverse of k, giving natural-order output.
  - Undefined: ram_rd_addr = k, for a core that already stores results in natural order. out_index behaviour is unchanged.

## Structure
- Shared package fft_pkg holds:
  - the LOG2N and DW defaults;
  - the state enum (IDLE, READ, DRAIN);
  - the bitrev function.
- One sub-module: fft_unload_fifo (4-entry sync FIFO, with count output used for credits).

## Test plan
- Single transform, out_ready=1, done_bank=1:
  - 1024 beats, the first at t+3.
  - Addresses 0, 512, 256, 768, … with bank 1.
  - out_last at index 1023; release at t+1027.
- Random out_ready with 30% stalls: every index 0..1023 delivered once and in order; data stable during stalls; never more than 3 outstanding reads.
- Second done mid-READ (bank 0): no overrun; the second transform's first read comes 1 cycle after release.
- Third done while a pending done is held: overrun=1 and stays set; the dropped bank is never read.
- reset_n low for 1 cycle at beat 500: all outputs 0 the next cycle; a later done restarts the stream at index 0.
- FFT_UNLOAD_BITREV_EN undefined: addresses 0, 1, 2, …, with out_index identical to the defined case.
